// File: rtl/toggle_activity_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : toggle_activity_monitor
//  Purpose  : Counts bit toggles per channel over a window of 2^WIN_LOG2
//             qualified (en=1) samples and latches per-channel counts, their
//             sum and a saturation flag when the window closes.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   1                  rising-edge clock
//    rst_n        in   1                  asynchronous active-low reset
//    start        in   1                  request a measurement window (IDLE only)
//    en           in   1                  sample-valid qualifier
//    sample_i     in   NUM_CH*CH_WIDTH    channel k at [k*CH_WIDTH +: CH_WIDTH]
//    rd_sel       in   max(1,clog2(NUM_CH)) channel select for rd_count
//    busy         out  1                  window in progress
//    done         out  1                  one-cycle pulse, results just latched
//    rd_count     out  CNT_WIDTH          latched count of channel rd_sel
//    total_count  out  CNT_WIDTH+4        latched sum of all channel counts
//    sat          out  1                  some channel saturated in latched window
//  Build option
//    ACT_CONTINUOUS_EN : back-to-back windows without returning to IDLE
// ============================================================================
module toggle_activity_monitor #(
    parameter int NUM_CH    = 4,
    parameter int CH_WIDTH  = 32,
    parameter int CNT_WIDTH = 24,
    parameter int WIN_LOG2  = 8,
    localparam int c_sel_w  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         en,
    input  logic [NUM_CH*CH_WIDTH-1:0]   sample_i,
    input  logic [c_sel_w-1:0]           rd_sel,
    output logic                         busy,
    output logic                         done,
    output logic [CNT_WIDTH-1:0]         rd_count,
    output logic [CNT_WIDTH+3:0]         total_count,
    output logic                         sat
);

`ifdef ACT_CONTINUOUS_EN
    localparam bit c_cont = 1'b1;
`else
    localparam bit c_cont = 1'b0;
`endif

    localparam int c_pc_w  = $clog2(CH_WIDTH + 1);
    localparam int c_sum_w = ((CNT_WIDTH > c_pc_w) ? CNT_WIDTH : c_pc_w) + 1;
    localparam int c_tot_w = CNT_WIDTH + 4;
    localparam logic [CNT_WIDTH-1:0] c_cnt_max  = {CNT_WIDTH{1'b1}};
    localparam logic [WIN_LOG2-1:0]  c_win_last = {WIN_LOG2{1'b1}};
    localparam logic [WIN_LOG2-1:0]  c_win_one  = WIN_LOG2'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        COUNT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                       state_q, state_d;
    logic [NUM_CH*CH_WIDTH-1:0]   prev_q, prev_d;
    logic [CNT_WIDTH-1:0]         cnt_q [NUM_CH];
    logic [CNT_WIDTH-1:0]         cnt_d [NUM_CH];
    logic [NUM_CH-1:0]            ovf_q, ovf_d;
    logic [WIN_LOG2-1:0]          win_q, win_d;
    logic [CNT_WIDTH-1:0]         res_cnt_q [NUM_CH];
    logic [CNT_WIDTH-1:0]         res_cnt_d [NUM_CH];
    logic                         res_sat_q, res_sat_d;
    logic [c_tot_w-1:0]           total_q, total_d;
    logic                         done_q, done_d;
    logic                         busy_q, busy_d;

    logic [NUM_CH*CH_WIDTH-1:0]   w_diff;
    logic [CNT_WIDTH-1:0]         w_cnt_next [NUM_CH];
    logic [NUM_CH-1:0]            w_ovf_next;
    logic [c_tot_w-1:0]           w_total;
    logic                         w_count_now;
    logic                         w_last;

    assign w_diff = sample_i ^ prev_q;

    // Per-channel popcount of the changed bits, added with saturation.
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic [c_pc_w-1:0]  w_pc;
        logic [c_sum_w-1:0] w_sum;
        logic               w_ovf;

        always_comb begin
            w_pc = '0;
            for (int b = 0; b < CH_WIDTH; b++) begin
                w_pc = w_pc + c_pc_w'(w_diff[k*CH_WIDTH + b]);
            end
        end

        assign w_sum         = c_sum_w'(cnt_q[k]) + c_sum_w'(w_pc);
        assign w_ovf         = (w_sum > c_sum_w'(c_cnt_max));
        assign w_cnt_next[k] = w_ovf ? c_cnt_max : w_sum[CNT_WIDTH-1:0];
        assign w_ovf_next[k] = ovf_q[k] | w_ovf;
    end

    always_comb begin
        w_total = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_total = w_total + c_tot_w'(w_cnt_next[k]);
        end
    end

    // In continuous mode the DONE cycle already belongs to the next window,
    // so a qualified sample there is counted exactly like in COUNT.
    assign w_count_now = en && ((state_q == COUNT) || (c_cont && (state_q == DONE)));
    assign w_last      = (win_q == c_win_last);

    always_comb begin
        state_d   = state_q;
        prev_d    = prev_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        win_d     = win_q;
        res_cnt_d = res_cnt_q;
        res_sat_d = res_sat_q;
        total_d   = total_q;
        done_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = PRIME;
                end
            end
            PRIME: begin
                if (en) begin
                    prev_d  = sample_i;
                    cnt_d   = '{default: '0};
                    ovf_d   = '0;
                    win_d   = '0;
                    state_d = COUNT;
                end
            end
            COUNT: begin
                state_d = COUNT;
            end
            DONE: begin
                state_d = c_cont ? COUNT : IDLE;
            end
        endcase

        if (w_count_now) begin
            prev_d = sample_i;
            cnt_d  = w_cnt_next;
            ovf_d  = w_ovf_next;
            win_d  = win_q + c_win_one;
            if (w_last) begin
                // Results are captured on the edge that takes the final
                // sample, so they are already valid while done is high.
                res_cnt_d = w_cnt_next;
                res_sat_d = |w_ovf_next;
                total_d   = w_total;
                done_d    = 1'b1;
                state_d   = DONE;
                if (c_cont) begin
                    cnt_d = '{default: '0};
                    ovf_d = '0;
                    win_d = '0;
                end
            end
        end

        busy_d = (state_d == PRIME) || (state_d == COUNT) ||
                 (c_cont && (state_d == DONE));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            prev_q    <= '0;
            cnt_q     <= '{default: '0};
            ovf_q     <= '0;
            win_q     <= '0;
            res_cnt_q <= '{default: '0};
            res_sat_q <= 1'b0;
            total_q   <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            prev_q    <= prev_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            win_q     <= win_d;
            res_cnt_q <= res_cnt_d;
            res_sat_q <= res_sat_d;
            total_q   <= total_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    // Out-of-range selects match no channel and read as zero.
    always_comb begin
        rd_count = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (rd_sel == c_sel_w'(k)) begin
                rd_count = res_cnt_q[k];
            end
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign sat         = res_sat_q;
    assign total_count = total_q;

endmodule
`default_nettype wire

// File: tb/tb_toggle_activity_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_toggle_activity_monitor
//  Purpose  : Directed self-checking bench with an expected-result queue.
//             dut      : NUM_CH=4, CH_WIDTH=32, CNT_WIDTH=24, WIN_LOG2=2
//             dut_sat  : same but CNT_WIDTH=4 (saturation)
//             dut5     : NUM_CH=5 (ch4 mirrors ch0) for out-of-range rd_sel
//  Revision : 1.0 - initial release
// ============================================================================
module tb_toggle_activity_monitor;

    typedef struct packed {
        logic [3:0][23:0] cnt;
        logic [27:0]      total;
        logic             sat;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n, start, en;
    logic [127:0]  sample;
    logic [159:0]  sample5;
    logic [1:0]    rd_sel, rd_sel_s;
    logic [2:0]    rd_sel5;
    logic          busy, done, sat, busy_s, done_s, sat_s, busy5, done5, sat5;
    logic [23:0]   rd_count, rd_count5;
    logic [27:0]   total_count, total5;
    logic [3:0]    rd_count_s;
    logic [7:0]    total_s;

    int   tests = 0;
    int   fails = 0;
    int   n_done = 0;
    exp_t sbq[$];
    exp_t last;
    exp_t mon_e;
    logic [127:0] win_s [5];

    assign sample5 = {sample[31:0], sample};

    always #5 clk = ~clk;

    toggle_activity_monitor #(.NUM_CH(4), .CH_WIDTH(32), .CNT_WIDTH(24), .WIN_LOG2(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .en(en), .sample_i(sample),
        .rd_sel(rd_sel), .busy(busy), .done(done), .rd_count(rd_count),
        .total_count(total_count), .sat(sat));

    toggle_activity_monitor #(.NUM_CH(4), .CH_WIDTH(32), .CNT_WIDTH(4), .WIN_LOG2(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .en(en), .sample_i(sample),
        .rd_sel(rd_sel_s), .busy(busy_s), .done(done_s), .rd_count(rd_count_s),
        .total_count(total_s), .sat(sat_s));

    toggle_activity_monitor #(.NUM_CH(5), .CH_WIDTH(32), .CNT_WIDTH(24), .WIN_LOG2(2)) dut5 (
        .clk(clk), .rst_n(rst_n), .start(start), .en(en), .sample_i(sample5),
        .rd_sel(rd_sel5), .busy(busy5), .done(done5), .rd_count(rd_count5),
        .total_count(total5), .sat(sat5));

    // Reference: toggle counts straight from the sample list (window of 4).
    function automatic exp_t model();
        exp_t e;
        int   acc;
        e = '0;
        for (int c = 0; c < 4; c++) begin
            acc = 0;
            for (int i = 1; i < 5; i++) begin
                acc += $countones(win_s[i][c*32 +: 32] ^ win_s[i-1][c*32 +: 32]);
            end
            e.cnt[c] = acc[23:0];
            e.total  = e.total + 28'(acc);
        end
        return e;
    endfunction

    // Scoreboard consumer: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            n_done++;
            tests++;
            if (sbq.size() == 0) begin
                fails++;
                $error("FAIL done_expected: done pulse with empty scoreboard");
            end
            if (sbq.size() > 0) begin
                mon_e = sbq.pop_front();
                tests++;
                if (total_count !== mon_e.total) begin
                    fails++;
                    $error("FAIL sb_total observed=%0h expected=%0h", total_count, mon_e.total);
                end
                tests++;
                if (sat !== mon_e.sat) begin
                    fails++;
                    $error("FAIL sb_sat observed=%0h expected=%0h", sat, mon_e.sat);
                end
                tests++;
                if (rd_count !== mon_e.cnt[rd_sel]) begin
                    fails++;
                    $error("FAIL sb_rd_count observed=%0h expected=%0h", rd_count, mon_e.cnt[rd_sel]);
                end
            end
        end
    end

    task automatic cyc(input logic s, input logic e, input logic [127:0] d);
        start  = s;
        en     = e;
        sample = d;
        @(posedge clk);
        #1;
    endtask

    task automatic sweep();
        for (int c = 0; c < 4; c++) begin
            rd_sel = 2'(c);
            #1;
            tests++;
            if (rd_count !== last.cnt[c]) begin
                fails++;
                $error("FAIL rd_count_sweep ch%0d observed=%0h expected=%0h", c, rd_count, last.cnt[c]);
            end
        end
        rd_sel = 2'd0;
    endtask

    task automatic run_window(input bit gap, input bit start_mid);
        string t;
        last = model();
        sbq.push_back(last);
        cyc(1'b1, 1'b0, '0);
        @(negedge clk);
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $error("FAIL busy_prime observed=%0h", busy);
        end
        for (int i = 0; i < 5; i++) begin
            cyc(start_mid && (i == 2), 1'b1, win_s[i]);
            if (gap && (i < 4)) cyc(1'b0, 1'b0, {$urandom, $urandom, $urandom, $urandom});
            @(negedge clk);
            t = (i == 4) ? "done_latency" : "done_early";
            tests++;
            if (done !== 1'(i == 4)) begin
                fails++;
                $error("FAIL %s observed=%0h sample=%0d", t, done, i);
            end
        end
        cyc(1'b0, 1'b0, '0);
        @(negedge clk);
        tests++;
        if (done !== 1'b0) begin
            fails++;
            $error("FAIL done_one_cycle observed=%0h", done);
        end
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $error("FAIL busy_after observed=%0h", busy);
        end
        sweep();
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; en = 1'b0; sample = '0;
        rd_sel = 2'd0; rd_sel_s = 2'd1; rd_sel5 = 3'd0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $error("FAIL rst_busy observed=%0h", busy);
        end
        tests++;
        if (done !== 1'b0) begin
            fails++;
            $error("FAIL rst_done observed=%0h", done);
        end
        tests++;
        if (sat !== 1'b0) begin
            fails++;
            $error("FAIL rst_sat observed=%0h", sat);
        end
        tests++;
        if (rd_count !== 24'd0) begin
            fails++;
            $error("FAIL rst_rd_count observed=%0h", rd_count);
        end
        tests++;
        if (total_count !== 28'd0) begin
            fails++;
            $error("FAIL rst_total observed=%0h", total_count);
        end

`ifdef ACT_CONTINUOUS_EN
        // Three back-to-back windows of constant ch0 toggling.
        for (int w = 0; w < 3; w++) begin
            last = '0;
            last.cnt[0] = 24'd128;
            last.total  = 28'd128;
            sbq.push_back(last);
        end
        cyc(1'b1, 1'b0, '0);
        cyc(1'b0, 1'b1, '0);
        for (int i = 1; i <= 12; i++) begin
            cyc((i == 5), 1'b1, (i % 2 == 1) ? 128'hFFFF_FFFF : 128'h0);
            @(negedge clk);
            tests++;
            if (done !== 1'(i % 4 == 0)) begin
                fails++;
                $error("FAIL cont_done observed=%0h sample=%0d", done, i);
            end
            tests++;
            if (busy !== 1'b1) begin
                fails++;
                $error("FAIL cont_busy observed=%0h sample=%0d", busy, i);
            end
        end
        tests++;
        if (n_done !== 3) begin
            fails++;
            $error("FAIL cont_done_count observed=%0d expected=3", n_done);
        end
        tests++;
        if (rd_count !== 24'd128) begin
            fails++;
            $error("FAIL cont_rd_count observed=%0h", rd_count);
        end
`else
        // ch0 alternates 0/FFFFFFFF, ch1 constant non-zero.
        for (int i = 0; i < 5; i++) begin
            win_s[i] = {32'h0, 32'h0, 32'hA5A5_A5A5, ((i % 2) == 1) ? 32'hFFFF_FFFF : 32'h0};
        end
        run_window(1'b0, 1'b0);
        tests++;
        if (total_count !== 28'd128) begin
            fails++;
            $error("FAIL req030_total observed=%0h", total_count);
        end

        // Same data with idle (en=0) cycles carrying junk between samples.
        run_window(1'b1, 1'b0);
        tests++;
        if (total_count !== 28'd128) begin
            fails++;
            $error("FAIL gap_total observed=%0h", total_count);
        end

        // Random data with start pulsed mid-window.
        for (int i = 0; i < 5; i++) begin
            win_s[i] = {$urandom, $urandom, $urandom, $urandom};
        end
        run_window(1'b0, 1'b1);
        rd_sel5 = 3'd4;
        #1;
        tests++;
        if (rd_count5 !== last.cnt[0]) begin
            fails++;
            $error("FAIL rd5_ch4 observed=%0h expected=%0h", rd_count5, last.cnt[0]);
        end
        for (int s = 5; s < 8; s++) begin
            rd_sel5 = 3'(s);
            #1;
            tests++;
            if (rd_count5 !== 24'd0) begin
                fails++;
                $error("FAIL rd5_out_of_range sel=%0d observed=%0h", s, rd_count5);
            end
        end

        // One-shot: further qualified samples after done start nothing.
        begin
            int nd0;
            nd0 = n_done;
            for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, {$urandom, $urandom, $urandom, $urandom});
            @(negedge clk);
            tests++;
            if (busy !== 1'b0) begin
                fails++;
                $error("FAIL oneshot_busy observed=%0h", busy);
            end
            tests++;
            if (n_done !== nd0) begin
                fails++;
                $error("FAIL oneshot_no_done observed=%0d expected=%0d", n_done, nd0);
            end
        end

        // ch1 toggles all bits every sample: 128 in 24 bits, 15+sat in 4 bits.
        for (int i = 0; i < 5; i++) begin
            win_s[i] = {32'h0, 32'h0, ((i % 2) == 1) ? 32'hFFFF_FFFF : 32'h0, 32'h1234_5678};
        end
        run_window(1'b0, 1'b0);
        tests++;
        if (rd_count_s !== 4'd15) begin
            fails++;
            $error("FAIL sat_rd_count observed=%0h", rd_count_s);
        end
        tests++;
        if (sat_s !== 1'b1) begin
            fails++;
            $error("FAIL sat_flag observed=%0h", sat_s);
        end
        tests++;
        if (total_s !== 8'd15) begin
            fails++;
            $error("FAIL sat_total observed=%0h", total_s);
        end

        // Reset in the middle of COUNT after two counted samples.
        cyc(1'b1, 1'b0, '0);
        cyc(1'b0, 1'b1, 128'h0);
        cyc(1'b0, 1'b1, 128'hFFFF_FFFF);
        cyc(1'b0, 1'b1, 128'h0);
        rst_n = 1'b0;
        #1;
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $error("FAIL midrst_busy observed=%0h", busy);
        end
        tests++;
        if (done !== 1'b0) begin
            fails++;
            $error("FAIL midrst_done observed=%0h", done);
        end
        tests++;
        if (sat_s !== 1'b0) begin
            fails++;
            $error("FAIL midrst_sat observed=%0h", sat_s);
        end
        tests++;
        if (total_count !== 28'd0) begin
            fails++;
            $error("FAIL midrst_total observed=%0h", total_count);
        end
        rd_sel = 2'd1;
        #1;
        tests++;
        if (rd_count !== 24'd0) begin
            fails++;
            $error("FAIL midrst_rd_count observed=%0h", rd_count);
        end
        rd_sel = 2'd0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, {$urandom, $urandom, $urandom, $urandom});
        @(negedge clk);
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $error("FAIL midrst_idle observed=%0h", busy);
        end
        for (int i = 0; i < 5; i++) begin
            win_s[i] = {$urandom, $urandom, $urandom, $urandom};
        end
        run_window(1'b0, 1'b0);
`endif

        cyc(1'b0, 1'b0, '0);
        tests++;
        if (sbq.size() !== 0) begin
            fails++;
            $error("FAIL scoreboard_empty observed=%0d", sbq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
